// File: rtl/mc_sequencer_if.sv
// Opcode handshake, microcode ROM port and issued-word bus of the mc8051 microcode sequencer.
interface mc_sequencer_if #(
  parameter int MCODE_WIDTH = 64
);
  logic                   i_op_valid;
  logic [7:0]             i_opcode;
  logic                   o_op_ready;
  logic                   i_irq_req;
  logic                   o_irq_ack;
  logic                   i_stall;
  logic                   i_flush;
  logic                   o_rom_en;
  logic [9:0]             o_rom_addr;
  logic [MCODE_WIDTH-1:0] i_rom_data;
  logic [MCODE_WIDTH-1:0] o_mc_b;
  logic                   o_mc_valid;
  logic [3:0]             o_t_p_q;
  logic [3:0]             o_t_p_d;
  logic                   o_uc_err;

  modport master (
    input  i_op_valid, i_opcode, i_irq_req, i_stall, i_flush, i_rom_data,
    output o_op_ready, o_irq_ack, o_rom_en, o_rom_addr, o_mc_b, o_mc_valid,
           o_t_p_q, o_t_p_d, o_uc_err
  );

  modport slave (
    output i_op_valid, i_opcode, i_irq_req, i_stall, i_flush, i_rom_data,
    input  o_op_ready, o_irq_ack, o_rom_en, o_rom_addr, o_mc_b, o_mc_valid,
           o_t_p_q, o_t_p_d, o_uc_err
  );
endinterface

// File: rtl/mc_sequencer.sv
// Microcode issue side of the mc8051 core: reads up to four microcode words per opcode and
// presents each for one machine cycle of PHASES clocks, inserting interrupt entry at boundaries.
//
// state | meaning
// IDLE  | instruction boundary, ready for an opcode or interrupt entry
// FETCH | ROM read of word {cyc_idx, opcode}
// LOAD  | ROM data arrives, captured into the issue register
// ISSUE | word held on o_mc_b while the T-phase counter runs
module mc_sequencer #(
  parameter int         MCODE_WIDTH = 64,
  parameter int         PHASES      = 6,
  parameter logic [7:0] IRQ_OPCODE  = 8'hA5
) (
  input  logic           clk,
  input  logic           reset_n,
  mc_sequencer_if.master bus
);

  localparam logic [3:0] LAST_PH = 4'(PHASES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_t;

  state_t                 state;
  state_t                 nxt_state;
  logic                   ready_q;
  logic                   irq_ack_q;
  logic                   uc_err_q;
  logic                   mc_valid_q;
  logic [7:0]             opcode_q;
  logic [1:0]             cyc_idx_q;
  logic [3:0]             phase_q;
  logic [MCODE_WIDTH-1:0] mc_b_q;

  logic take_irq;
  logic take_op;
  logic chain;
  logic uc_err_set;
  logic last_ph;

  assign last_ph = (phase_q == LAST_PH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt_state;
  end

  // o_op_ready is registered, so interrupt entry and flush simply decline the opcode offered
  // in the same clock; fetch keeps it valid and it is taken at the next boundary.
  always_comb begin
    nxt_state  = state;
    take_irq   = 1'b0;
    take_op    = 1'b0;
    chain      = 1'b0;
    uc_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (ready_q && !bus.i_flush) begin
          if (bus.i_irq_req) begin
            take_irq  = 1'b1;
            nxt_state = FETCH;
          end else if (bus.i_op_valid) begin
            take_op   = 1'b1;
            nxt_state = FETCH;
          end
        end
      end
      FETCH: nxt_state = bus.i_flush ? IDLE : LOAD;
      LOAD:  nxt_state = bus.i_flush ? IDLE : ISSUE;
      ISSUE: begin
        if (bus.i_flush) begin
          nxt_state = IDLE;
        end else if (!bus.i_stall && last_ph) begin
          if (mc_b_q[MCODE_WIDTH-1] && cyc_idx_q != 2'd3) begin
            chain     = 1'b1;
            nxt_state = FETCH;
          end else begin
            uc_err_set = mc_b_q[MCODE_WIDTH-1];
            nxt_state  = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q    <= 1'b0;
      irq_ack_q  <= 1'b0;
      uc_err_q   <= 1'b0;
      mc_valid_q <= 1'b0;
      opcode_q   <= 8'h00;
      cyc_idx_q  <= 2'd0;
      phase_q    <= 4'd0;
      mc_b_q     <= '0;
    end else begin
      ready_q    <= (nxt_state == IDLE);
      irq_ack_q  <= take_irq;
      uc_err_q   <= uc_err_set;
      mc_valid_q <= (state == LOAD) && (nxt_state == ISSUE);

      if (take_irq)     opcode_q <= IRQ_OPCODE;
      else if (take_op) opcode_q <= bus.i_opcode;

      if (take_irq || take_op || nxt_state == IDLE) cyc_idx_q <= 2'd0;
      else if (chain)                               cyc_idx_q <= cyc_idx_q + 2'd1;

      if (state == LOAD && nxt_state == ISSUE) mc_b_q <= bus.i_rom_data;
      else if (nxt_state != ISSUE)             mc_b_q <= '0;

      if (nxt_state != ISSUE)                    phase_q <= 4'd0;
      else if (state == ISSUE && !bus.i_stall)   phase_q <= phase_q + 4'd1;
    end
  end

  assign bus.o_op_ready = ready_q;
  assign bus.o_irq_ack  = irq_ack_q;
  assign bus.o_uc_err   = uc_err_q;
  assign bus.o_mc_valid = mc_valid_q;
  assign bus.o_mc_b     = mc_b_q;
  assign bus.o_rom_en   = (state == FETCH);
  assign bus.o_rom_addr = (state == FETCH) ? {cyc_idx_q, opcode_q} : 10'd0;
  assign bus.o_t_p_q    = phase_q;
  assign bus.o_t_p_d    = (state != ISSUE) ? 4'd0 : (last_ph ? 4'd0 : phase_q + 4'd1);

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed cases plus randomized instructions checked against a
// transaction-level plan (word count, continuation bits, stall/flush points) and a ROM model.
module tb_mc_sequencer;

  localparam int         MW     = 64;
  localparam int         PHASES = 6;
  localparam logic [7:0] IRQ_OP = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic [MW-1:0] rom [1024];
  logic [MW-1:0] rom_q = '0;

  mc_sequencer_if #(.MCODE_WIDTH(MW)) bus ();

  mc_sequencer #(.MCODE_WIDTH(MW), .PHASES(PHASES), .IRQ_OPCODE(IRQ_OP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROM: data valid the clock after the read enable
  always @(posedge clk) if (bus.o_rom_en) rom_q <= rom[bus.o_rom_addr];
  assign bus.i_rom_data = rom_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // words below nw-1 carry the continuation bit; word nw-1 carries last_msb
  task automatic fill_rom(input logic [7:0] op, input int nw, input bit last_msb);
    for (int k = 0; k < 4; k++) begin
      logic msb;
      logic [9:0] a;
      a = {2'(k), op};
      if (k < nw - 1)       msb = 1'b1;
      else if (k == nw - 1) msb = last_msb;
      else                  msb = 1'($urandom);
      rom[a] = {msb, 31'($urandom), 32'($urandom)};
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 40 && bus.o_op_ready !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", 64'(bus.o_op_ready), 64'(1));
  endtask

  // entered at the negedge of the first FETCH clock
  task automatic run_words(input logic [7:0] op, input int nw, input bit last_msb, input bit is_irq,
                           input int stall_w, input int stall_p, input int stall_n,
                           input int flush_w, input int flush_p);
    int unsigned c0;
    bit flushed;
    c0 = cyc;
    flushed = 1'b0;
    for (int k = 0; k < nw && !flushed; k++) begin
      logic [MW-1:0] word;
      int p, stalls_left;
      bit first, stalled;
      chk("rom_en", 64'(bus.o_rom_en), 64'(1));
      chk("rom_addr", 64'(bus.o_rom_addr), 64'({2'(k), op}));
      chk("irq_ack", 64'(bus.o_irq_ack), 64'(is_irq && k == 0));
      chk("gap_mc_b", bus.o_mc_b, 64'(0));
      @(negedge clk);
      chk("load_t_p_q", 64'(bus.o_t_p_q), 64'(0));
      chk("load_rom_en", 64'(bus.o_rom_en), 64'(0));
      @(negedge clk);
      word = rom[{2'(k), op}];
      p = 0;
      first = 1'b1;
      stalls_left = (k == stall_w) ? stall_n : 0;
      forever begin
        chk("t_p_q", 64'(bus.o_t_p_q), 64'(p));
        chk("t_p_d", 64'(bus.o_t_p_d), 64'((p == PHASES - 1) ? 0 : p + 1));
        chk("mc_b", bus.o_mc_b, word);
        chk("mc_valid", 64'(bus.o_mc_valid), 64'(first));
        first = 1'b0;
        if (k == flush_w && p == flush_p) begin
          bus.i_flush = 1'b1;
          @(negedge clk);
          bus.i_flush = 1'b0;
          chk("flush_mc_b", bus.o_mc_b, 64'(0));
          chk("flush_ready", 64'(bus.o_op_ready), 64'(1));
          chk("flush_t_p_q", 64'(bus.o_t_p_q), 64'(0));
          chk("flush_err", 64'(bus.o_uc_err), 64'(0));
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_rom", 64'(bus.o_rom_en), 64'(0));
          end
          flushed = 1'b1;
          break;
        end
        stalled = (p == stall_p) && (stalls_left > 0);
        if (stalled) stalls_left--;
        bus.i_stall = stalled;
        @(negedge clk);
        bus.i_stall = 1'b0;
        if (!stalled) begin
          if (p == PHASES - 1) break;
          p++;
        end
      end
    end
    if (!flushed) begin
      chk("end_uc_err", 64'(bus.o_uc_err), 64'(nw == 4 && last_msb));
      chk("end_ready", 64'(bus.o_op_ready), 64'(1));
      chk("end_mc_b", bus.o_mc_b, 64'(0));
      chk("end_t_p_q", 64'(bus.o_t_p_q), 64'(0));
      chk("end_rom_en", 64'(bus.o_rom_en), 64'(0));
      chk("elapsed", 64'(cyc - c0),
          64'(nw * (PHASES + 2) + ((stall_w >= 0 && stall_w < nw) ? stall_n : 0)));
    end
  endtask

  task automatic issue_op(input logic [7:0] op, input int nw, input bit last_msb, input bit with_irq,
                          input int stall_w, input int stall_p, input int stall_n,
                          input int flush_w, input int flush_p);
    fill_rom(op, nw, last_msb);
    if (with_irq) fill_rom(IRQ_OP, 1, 1'b0);
    wait_ready();
    bus.i_opcode   = op;
    bus.i_op_valid = 1'b1;
    bus.i_irq_req  = with_irq;
    @(negedge clk);
    if (with_irq) begin
      bus.i_irq_req = 1'b0;
      run_words(IRQ_OP, 1, 1'b0, 1'b1, -1, 0, 0, -1, 0);
      @(negedge clk);
    end
    bus.i_op_valid = 1'b0;
    run_words(op, nw, last_msb, 1'b0, stall_w, stall_p, stall_n, flush_w, flush_p);
  endtask

  initial begin
    bus.i_op_valid = 1'b0;
    bus.i_opcode   = 8'h00;
    bus.i_irq_req  = 1'b0;
    bus.i_stall    = 1'b0;
    bus.i_flush    = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.o_op_ready), 64'(0));
    chk("rst_mc_b", bus.o_mc_b, 64'(0));
    chk("rst_rom_en", 64'(bus.o_rom_en), 64'(0));
    chk("rst_mc_valid", 64'(bus.o_mc_valid), 64'(0));
    chk("rst_t_p_q", 64'(bus.o_t_p_q), 64'(0));
    chk("rst_t_p_d", 64'(bus.o_t_p_d), 64'(0));
    reset_n = 1'b1;
    #1 chk("rel_ready", 64'(bus.o_op_ready), 64'(0));
    @(negedge clk);
    chk("first_clk_ready", 64'(bus.o_op_ready), 64'(1));

    issue_op(8'h04, 1, 1'b0, 1'b0, -1, 0, 0, -1, 0);
    issue_op(8'h12, 3, 1'b0, 1'b0, -1, 0, 0, -1, 0);
    issue_op(8'h33, 2, 1'b0, 1'b1, -1, 0, 0, -1, 0);
    issue_op(8'h40, 1, 1'b0, 1'b0, 0, 2, 3, -1, 0);
    issue_op(8'h7E, 4, 1'b1, 1'b0, -1, 0, 0, -1, 0);
    issue_op(8'h7F, 4, 1'b1, 1'b0, -1, 0, 0, 1, 3);

    // reset in the middle of a word
    fill_rom(8'h55, 2, 1'b0);
    wait_ready();
    bus.i_opcode   = 8'h55;
    bus.i_op_valid = 1'b1;
    @(negedge clk);
    bus.i_op_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_mc_b", bus.o_mc_b, 64'(0));
    chk("midrst_t_p_q", 64'(bus.o_t_p_q), 64'(0));
    chk("midrst_ready", 64'(bus.o_op_ready), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rom", 64'(bus.o_rom_en), 64'(0));
      chk("midrst_no_word", 64'(bus.o_mc_valid), 64'(0));
    end

    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      int nw, sw, sp, sn, fw, fp;
      bit lm, irq;
      op = 8'($urandom);
      if (op == IRQ_OP) op = 8'h00;
      nw  = $urandom_range(1, 4);
      lm  = (nw == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      sw  = $urandom_range(0, 4);
      sp  = $urandom_range(0, PHASES - 1);
      sn  = $urandom_range(1, 3);
      fw  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, nw - 1) : -1;
      fp  = $urandom_range(0, PHASES - 1);
      irq = ($urandom_range(0, 3) == 0);
      issue_op(op, nw, lm, irq, sw, sp, sn, fw, fp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
